sw_debounce: RTL and testbench

Switch-conditioning stage in front of the DE2 adder examples. It takes raw, bouncing slide-switch levels and drives clean debounced levels plus one-cycle edge pulses. The debounced levels feed the half-adder's `SW` inputs directly. The edge pulses are available to later sequential stages such as accumulators and counters.

---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/sw_debounce_cell.sv | 92 +++++++++
 rtl/sw_debounce.sv | 58 +++++
 tb/tb_sw_debounce.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and channel state encoding for the sw_debounce switch conditioner.
// The SW_DEBOUNCE_SYNC_EN macro (used by sw_debounce_cell) selects the input synchronizer.
package sw_debounce_pkg;

    localparam int SW_DB_STABLE_DEFAULT = 1_000_000;
    localparam int SW_DB_SYNC_STAGES    = 2;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sw_debounce_cell.sv
// One debounce channel: optional two-flop synchronizer, STABLE/CHANGING FSM and edge pulses.
// Define SW_DEBOUNCE_SYNC_EN to insert the synchronizer on real board inputs.
module sw_debounce_cell
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = SW_DB_STABLE_DEFAULT,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    input  logic valid,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             samp_s;
    db_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             db_r;
    logic             rise_r;
    logic             fall_r;

`ifdef SW_DEBOUNCE_SYNC_EN
    logic [SW_DB_SYNC_STAGES-1:0] sync_r;

    // Two-flop synchronizer bringing the asynchronous switch into the clock domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SW_DB_SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SW_DB_SYNC_STAGES-2:0], sw};
        end
    end

    assign samp_s = sync_r[SW_DB_SYNC_STAGES-1];
`else
    assign samp_s = sw;
`endif

    // Debounce FSM: the first differing sample already counts as one stable cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_STABLE;
            cnt_r   <= CNT_ZERO;
            db_r    <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            case (state_r)
                ST_STABLE: begin
                    if (samp_s != db_r) begin
                        state_r <= ST_CHANGING;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_CHANGING: begin
                    if (samp_s == db_r) begin
                        state_r <= ST_STABLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= ST_STABLE;
                        cnt_r   <= CNT_ZERO;
                        db_r    <= samp_s;
                        rise_r  <= valid & samp_s;
                        fall_r  <= valid & ~samp_s;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_STABLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign db   = db_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer with startup settling flag; SW_VALID gates the edge pulses.
// Build option: SW_DEBOUNCE_SYNC_EN adds a two-flop synchronizer per channel.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int N_SW          = 2,
    parameter int STABLE_CYCLES = SW_DB_STABLE_DEFAULT,
    parameter int CNT_W         = 20
) (
    input  logic            CLOCK_50,
    input  logic            RST_n,
    input  logic [N_SW-1:0] SW,
    output logic [N_SW-1:0] SW_DB,
    output logic [N_SW-1:0] SW_RISE,
    output logic [N_SW-1:0] SW_FALL,
    output logic            SW_VALID
);

    localparam logic [CNT_W-1:0] VALID_AT = CNT_W'(STABLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] start_cnt_r;
    logic             valid_r;

    // Startup counter: SW_VALID rises on the (STABLE_CYCLES+3)-th edge after release and holds
    always_ff @(posedge CLOCK_50) begin
        if (!RST_n) begin
            start_cnt_r <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
        end else if (!valid_r) begin
            if (start_cnt_r == VALID_AT) begin
                valid_r     <= 1'b1;
            end else begin
                start_cnt_r <= start_cnt_r + CNT_ONE;
            end
        end else begin
            valid_r <= 1'b1;
        end
    end

    assign SW_VALID = valid_r;

    for (genvar g = 0; g < N_SW; g++) begin : g_ch
        sw_debounce_cell #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_cell (
            .clk   (CLOCK_50),
            .rst_n (RST_n),
            .sw    (SW[g]),
            .valid (valid_r),
            .db    (SW_DB[g]),
            .rise  (SW_RISE[g]),
            .fall  (SW_FALL[g])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios plus random toggling vs. a run-length model.
module tb_sw_debounce;

    localparam int SC = 4;
    localparam int N  = 2;
    localparam int CW = 4;
`ifdef SW_DEBOUNCE_SYNC_EN
    localparam int LAT   = SC + 2;
    localparam int DELAY = 2;
`else
    localparam int LAT   = SC;
    localparam int DELAY = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sw;
    logic [N-1:0] sw_db;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic         sw_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: a level is accepted after SC consecutive differing samples
    logic [N-1:0] h0, h1;
    logic [N-1:0] m_db, m_rise, m_fall;
    logic         m_valid;
    int           run [N];
    int           rel;

    sw_debounce #(.N_SW(N), .STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .CLOCK_50 (clk),
        .RST_n    (rst_n),
        .SW       (sw),
        .SW_DB    (sw_db),
        .SW_RISE  (sw_rise),
        .SW_FALL  (sw_fall),
        .SW_VALID (sw_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [N-1:0] s;
        @(posedge clk);
        if (!rst_n) begin
            h0 = '0; h1 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_valid = 1'b0;
            for (int i = 0; i < N; i++) run[i] = 0;
            rel = 0;
        end else begin
            s = (DELAY == 2) ? h1 : sw;
            for (int i = 0; i < N; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (s[i] !== m_db[i]) begin
                    run[i]++;
                    if (run[i] == SC) begin
                        m_db[i]   = s[i];
                        m_rise[i] = m_valid & s[i];
                        m_fall[i] = m_valid & ~s[i];
                        run[i]    = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            rel++;
            if (rel >= SC + 3) m_valid = 1'b1;
            h1 = h0;
            h0 = sw;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int first_valid = -1;
        rst_n = 1'b0; sw = 2'b00;
        tick(); tick();
        checks++;
        if ({sw_db, sw_rise, sw_fall, sw_valid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {sw_db, sw_rise, sw_fall, sw_valid}, 7'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= SC + 4; k++) begin
            tick();
            if (first_valid < 0 && sw_valid === 1'b1) first_valid = k;
            checks++;
            if ({sw_db, sw_rise, sw_fall, sw_valid} !== {m_db, m_rise, m_fall, m_valid}) begin
                failures++;
                $display("FAIL reset_model k=%0d got=%b exp=%b", k,
                         {sw_db, sw_rise, sw_fall, sw_valid}, {m_db, m_rise, m_fall, m_valid});
            end
        end
        checks++;
        if (first_valid !== SC + 3) begin
            failures++;
            $display("FAIL valid_edge got=%0d exp=%0d", first_valid, SC + 3);
        end
    endtask

    task automatic test_clean_rise();
        int first_rise = -1;
        int n_rise = 0;
        int n_fall = 0;
        sw = 2'b01;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (sw_rise[0] === 1'b1) begin
                n_rise++;
                if (first_rise < 0) first_rise = k;
            end
            if (sw_fall !== 2'b00) n_fall++;
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                failures++;
                $display("FAIL rise_model k=%0d got=%b exp=%b", k,
                         {sw_db, sw_rise, sw_fall}, {m_db, m_rise, m_fall});
            end
        end
        checks++;
        if (first_rise !== LAT || n_rise !== 1 || n_fall !== 0 || sw_db !== 2'b01) begin
            failures++;
            $display("FAIL clean_rise got edge=%0d pulses=%0d falls=%0d db=%b exp edge=%0d pulses=1 falls=0 db=01",
                     first_rise, n_rise, n_fall, sw_db, LAT);
        end
    endtask

    task automatic test_bounce();
        int first_db = -1;
        int n_rise = 0;
        logic [3:0] pat;
        pat = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            sw[1] = pat[3-k];
            tick();
            checks++;
            if (sw_db[1] !== 1'b0 || sw_rise[1] !== 1'b0) begin
                failures++;
                $display("FAIL bounce_hold k=%0d got db=%b rise=%b exp db=0 rise=0", k, sw_db[1], sw_rise[1]);
            end
        end
        sw[1] = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (first_db < 0 && sw_db[1] === 1'b1) first_db = k;
            if (sw_rise[1] === 1'b1) n_rise++;
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                failures++;
                $display("FAIL bounce_model k=%0d got=%b exp=%b", k,
                         {sw_db, sw_rise, sw_fall}, {m_db, m_rise, m_fall});
            end
        end
        checks++;
        if (first_db !== LAT || n_rise !== 1) begin
            failures++;
            $display("FAIL bounce_settle got edge=%0d pulses=%0d exp edge=%0d pulses=1", first_db, n_rise, LAT);
        end
    endtask

    task automatic test_high_through_reset();
        int n_rise = 0;
        logic [N-1:0] db_at_valid;
        db_at_valid = 2'bxx;
        rst_n = 1'b0; sw = 2'b11;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 1; k <= SC + 4; k++) begin
            tick();
            if (sw_rise !== 2'b00) n_rise++;
            if (k == SC + 3) db_at_valid = sw_db;
            checks++;
            if ({sw_db, sw_rise, sw_fall, sw_valid} !== {m_db, m_rise, m_fall, m_valid}) begin
                failures++;
                $display("FAIL high_model k=%0d got=%b exp=%b", k,
                         {sw_db, sw_rise, sw_fall, sw_valid}, {m_db, m_rise, m_fall, m_valid});
            end
        end
        checks++;
        if (n_rise !== 0 || db_at_valid !== 2'b11) begin
            failures++;
            $display("FAIL high_reset got pulses=%0d db=%b exp pulses=0 db=11", n_rise, db_at_valid);
        end
    endtask

    task automatic test_simultaneous();
        int both = -1;
        sw = 2'b01;
        for (int k = 1; k <= LAT + 2; k++) tick();
        sw = 2'b10;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick();
            if (both < 0 && sw_fall[0] === 1'b1 && sw_rise[1] === 1'b1) both = k;
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                failures++;
                $display("FAIL simul_model k=%0d got=%b exp=%b", k,
                         {sw_db, sw_rise, sw_fall}, {m_db, m_rise, m_fall});
            end
        end
        checks++;
        if (both !== LAT || sw_db !== 2'b10) begin
            failures++;
            $display("FAIL simultaneous got edge=%0d db=%b exp edge=%0d db=10", both, sw_db, LAT);
        end
    endtask

    task automatic test_reset_mid_count();
        int first_db = -1;
        int first_valid = -1;
        sw = 2'b11;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({sw_db, sw_rise, sw_fall, sw_valid} !== 7'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b exp=%b", {sw_db, sw_rise, sw_fall, sw_valid}, 7'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= SC + 4; k++) begin
            tick();
            if (first_db < 0 && sw_db[0] === 1'b1) first_db = k;
            if (first_valid < 0 && sw_valid === 1'b1) first_valid = k;
            checks++;
            if ({sw_db, sw_rise, sw_fall, sw_valid} !== {m_db, m_rise, m_fall, m_valid}) begin
                failures++;
                $display("FAIL mid_model k=%0d got=%b exp=%b", k,
                         {sw_db, sw_rise, sw_fall, sw_valid}, {m_db, m_rise, m_fall, m_valid});
            end
        end
        checks++;
        if (first_db !== LAT || first_valid !== SC + 3) begin
            failures++;
            $display("FAIL mid_restart got db_edge=%0d valid_edge=%0d exp db_edge=%0d valid_edge=%0d",
                     first_db, first_valid, LAT, SC + 3);
        end
    endtask

    task automatic test_random();
        int hold;
        for (int n = 0; n < 80; n++) begin
            sw    = N'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
            hold  = $urandom_range(1, LAT + 3);
            for (int k = 0; k < hold; k++) begin
                tick();
                rst_n = 1'b1;
                checks++;
                if ({sw_db, sw_rise, sw_fall, sw_valid} !== {m_db, m_rise, m_fall, m_valid}) begin
                    failures++;
                    $display("FAIL random n=%0d k=%0d got=%b exp=%b", n, k,
                             {sw_db, sw_rise, sw_fall, sw_valid}, {m_db, m_rise, m_fall, m_valid});
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = 2'b00;
        @(negedge clk);
        test_reset();
        test_clean_rise();
        test_bounce();
        test_high_through_reset();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
